// File: rtl/dma_bus_arbiter_if.sv
// Purpose: DMA start/end interrupts, BR/BG handshake and CPU hold/status signals.
// Latency: none, wiring only.
// Backpressure: BR/BG handshake; bus_hold stalls new CPU data-memory accesses.
interface dma_bus_arbiter_if #(
   parameter int WORD_SIZE = 16
);
   logic                 dma_begin;
   logic                 dma_end;
   logic                 BR;
   logic                 cpu_mem_busy;
   logic                 BG;
   logic                 cmd;
   logic [WORD_SIZE-1:0] cmd_addr;
   logic [WORD_SIZE-1:0] cmd_length;
   logic                 bus_hold;
   logic                 done_irq;
   logic                 busy;
   logic                 overrun;
   logic [WORD_SIZE-1:0] grant_cycles;

   // Arbiter side: consumes interrupts and the bus request, drives grant and status.
   modport slave (
      input  dma_begin, dma_end, BR, cpu_mem_busy,
      output BG, cmd, cmd_addr, cmd_length, bus_hold, done_irq, busy, overrun, grant_cycles
   );

   // Environment side: external device, DMA engine and CPU.
   modport master (
      output dma_begin, dma_end, BR, cpu_mem_busy,
      input  BG, cmd, cmd_addr, cmd_length, bus_hold, done_irq, busy, overrun, grant_cycles
   );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Purpose: CPU-side DMA responder: issues the DMA command, grants the bus after CPU drain, signals completion.
// Latency: every output is registered; dma_begin -> cmd is 1 cycle, BR -> BG is 1 cycle when the CPU is idle.
// Backpressure: BG is withheld while cpu_mem_busy is high; bus_hold stalls the CPU while the DMA owns the bus.
module dma_bus_arbiter #(
   parameter int                   WORD_SIZE = 16,
   parameter logic [WORD_SIZE-1:0] DMA_ADDR  = 16'h01F4,
   parameter logic [WORD_SIZE-1:0] DMA_LEN   = 16'd12
) (
   input  logic              clk,
   input  logic              reset,
   dma_bus_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CMD      = 3'd1,
      S_WAIT_BR  = 3'd2,
      S_DRAIN    = 3'd3,
      S_GRANT    = 3'd4,
      S_WAIT_END = 3'd5
   } state_t;

   localparam logic [WORD_SIZE-1:0] CNT_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};
   localparam logic [WORD_SIZE-1:0] CNT_MAX = '1;

   state_t               state_q, state_d;
   logic                 pending_q, pending_d;
   logic                 end_seen_q, end_seen_d;
   logic                 overrun_q, overrun_d;
   logic                 dma_begin_q;
   logic [WORD_SIZE-1:0] grant_cycles_q, grant_cycles_d;
   logic                 bg_q, bg_d;
   logic                 cmd_q, cmd_d;
   logic [WORD_SIZE-1:0] cmd_addr_q, cmd_addr_d;
   logic [WORD_SIZE-1:0] cmd_length_q, cmd_length_d;
   logic                 bus_hold_q, bus_hold_d;
   logic                 done_irq_q, done_irq_d;
   logic                 busy_q, busy_d;
   logic                 begin_rise;

   // A held dma_begin must only queue one request, so outside IDLE we react to its rising edge.
   assign begin_rise = bus.dma_begin & ~dma_begin_q;

   // State and all registered outputs; reset wins over everything, including a live grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         pending_q      <= 1'b0;
         end_seen_q     <= 1'b0;
         overrun_q      <= 1'b0;
         dma_begin_q    <= 1'b0;
         grant_cycles_q <= '0;
         bg_q           <= 1'b0;
         cmd_q          <= 1'b0;
         cmd_addr_q     <= '0;
         cmd_length_q   <= '0;
         bus_hold_q     <= 1'b0;
         done_irq_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         end_seen_q     <= end_seen_d;
         overrun_q      <= overrun_d;
         dma_begin_q    <= bus.dma_begin;
         grant_cycles_q <= grant_cycles_d;
         bg_q           <= bg_d;
         cmd_q          <= cmd_d;
         cmd_addr_q     <= cmd_addr_d;
         cmd_length_q   <= cmd_length_d;
         bus_hold_q     <= bus_hold_d;
         done_irq_q     <= done_irq_d;
         busy_q         <= busy_d;
      end
   end

   // Next-state: command, wait for BR, drain the CPU access, grant, then wait for the end interrupt.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.dma_begin || pending_q) state_d = S_CMD;
         end
         S_CMD: begin
            state_d = S_WAIT_BR;
         end
         S_WAIT_BR: begin
            if (bus.BR) state_d = bus.cpu_mem_busy ? S_DRAIN : S_GRANT;
         end
         S_DRAIN: begin
            if (!bus.cpu_mem_busy) state_d = S_GRANT;
         end
         S_GRANT: begin
            if (!bus.BR) state_d = (end_seen_q || bus.dma_end) ? S_IDLE : S_WAIT_END;
         end
         S_WAIT_END: begin
            if (bus.dma_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request queueing, end capture during the grant and the grant-length counter.
   always_comb begin
      pending_d      = pending_q;
      overrun_d      = overrun_q;
      end_seen_d     = 1'b0;
      grant_cycles_d = grant_cycles_q;
      if (state_q == S_IDLE) begin
         if (state_d == S_CMD) pending_d = 1'b0;
      end else if (begin_rise) begin
         if (pending_q) overrun_d = 1'b1;
         else           pending_d = 1'b1;
      end
      if (state_q == S_GRANT && state_d == S_GRANT) end_seen_d = end_seen_q | bus.dma_end;
      if (state_d == S_GRANT) begin
         if (state_q != S_GRANT)           grant_cycles_d = CNT_ONE;
         else if (grant_cycles_q != CNT_MAX) grant_cycles_d = grant_cycles_q + CNT_ONE;
      end
   end

   // Output decode from the upcoming state so every output comes straight from a flop.
   always_comb begin
      bg_d         = (state_d == S_GRANT);
      cmd_d        = (state_d == S_CMD);
      cmd_addr_d   = (state_d == S_CMD) ? DMA_ADDR : '0;
      cmd_length_d = (state_d == S_CMD) ? DMA_LEN : '0;
      bus_hold_d   = (state_d == S_DRAIN) || (state_d == S_GRANT);
      busy_d       = (state_d != S_IDLE);
      done_irq_d   = (state_d == S_IDLE) && ((state_q == S_GRANT) || (state_q == S_WAIT_END));
   end

   assign bus.BG           = bg_q;
   assign bus.cmd          = cmd_q;
   assign bus.cmd_addr     = cmd_addr_q;
   assign bus.cmd_length   = cmd_length_q;
   assign bus.bus_hold     = bus_hold_q;
   assign bus.done_irq     = done_irq_q;
   assign bus.busy         = busy_q;
   assign bus.overrun      = overrun_q;
   assign bus.grant_cycles = grant_cycles_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Purpose: self-checking bench for dma_bus_arbiter with randomized transfer timelines.
// Latency: expectations derived from the transfer phases (launch, wait, drain, grant, end).
// Backpressure: exercises BR withheld by cpu_mem_busy and late dma_end after BR release.
module tb_dma_bus_arbiter;
   localparam int            W    = 16;
   localparam logic [W-1:0]  ADDR = 16'h01F4;
   localparam logic [W-1:0]  LEN  = 16'd12;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   // Reference model of the request queue: one outstanding request, sticky overrun.
   bit   pend_m = 1'b0;
   bit   ovr_m  = 1'b0;

   dma_bus_arbiter_if #(.WORD_SIZE(W)) bus ();

   dma_bus_arbiter #(.WORD_SIZE(W), .DMA_ADDR(ADDR), .DMA_LEN(LEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] obs();
      return {bus.BG, bus.cmd, bus.bus_hold, bus.done_irq, bus.busy, bus.overrun};
   endfunction

   task automatic idle_inputs();
      bus.dma_begin = 1'b0; bus.dma_end = 1'b0; bus.BR = 1'b0; bus.cpu_mem_busy = 1'b0;
   endtask

   // One complete transfer: w wait cycles before BR, d drain cycles, L grant cycles,
   // end mode 0 = with BR drop, 1 = pulse during grant, 2 = e cycles after drop.
   // extra = dma_begin pulses injected during the grant (pending, then overrun).
   task automatic do_transfer(input bit via_pending, input int w, input int d, input int L,
                              input int mode, input int e, input int extra, input string tag);
      logic [5:0] exp;
      int         end_at;
      bit         fin;
      end_at = (L > 1) ? $urandom_range(1, L - 1) : 1;
      // launch: BR and dma_end in IDLE must be ignored
      bus.BR = 1'($urandom_range(0, 1)); bus.dma_end = 1'($urandom_range(0, 1));
      bus.cpu_mem_busy = 1'($urandom_range(0, 1));
      bus.dma_begin = !via_pending;
      if (via_pending) pend_m = 1'b0;
      step();
      bus.dma_begin = 1'b0;
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ovr_m};
      total++;
      if (obs() !== exp || bus.cmd_addr !== ADDR || bus.cmd_length !== LEN) begin
         bad++;
         $display("FAIL %s cmd: {BG,cmd,hold,done,busy,ovr}=%b addr=%h len=%0d, want %b addr=%h len=%0d",
                  tag, obs(), bus.cmd_addr, bus.cmd_length, exp, ADDR, LEN);
      end
      // cycle with CMD active: BR is ignored here
      bus.BR = 1'($urandom_range(0, 1)); bus.dma_end = 1'($urandom_range(0, 1));
      step();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ovr_m};
      total++;
      if (obs() !== exp || bus.cmd_addr !== '0 || bus.cmd_length !== '0) begin
         bad++;
         $display("FAIL %s post_cmd: %b addr=%h len=%0d, want %b addr=0 len=0",
                  tag, obs(), bus.cmd_addr, bus.cmd_length, exp);
      end
      // waiting for BR; dma_end is ignored before the grant
      for (int i = 0; i < w; i++) begin
         bus.BR = 1'b0; bus.dma_end = 1'($urandom_range(0, 1));
         bus.cpu_mem_busy = 1'($urandom_range(0, 1));
         step();
         total++;
         if (obs() !== exp) begin
            bad++; $display("FAIL %s wait_br[%0d]: %b want %b", tag, i, obs(), exp);
         end
      end
      // BR while the CPU still has an access in flight
      bus.BR = 1'b1; bus.cpu_mem_busy = 1'b1;
      for (int i = 0; i < d; i++) begin
         bus.dma_end = 1'($urandom_range(0, 1));
         step();
         exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ovr_m};
         total++;
         if (obs() !== exp) begin
            bad++; $display("FAIL %s drain[%0d]: %b want %b", tag, i, obs(), exp);
         end
      end
      bus.cpu_mem_busy = 1'b0; bus.dma_end = 1'b0;
      step();
      exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ovr_m};
      total++;
      if (obs() !== exp || bus.grant_cycles !== 16'd1) begin
         bad++; $display("FAIL %s grant_start: %b cnt=%0d, want %b cnt=1", tag, obs(), bus.grant_cycles, exp);
      end
      // grant held; optional dma_begin pulses and early dma_end
      for (int j = 1; j < L; j++) begin
         bus.BR = 1'b1; bus.cpu_mem_busy = 1'($urandom_range(0, 1));
         bus.dma_end = (mode == 1 && j == end_at);
         bus.dma_begin = (j % 2 == 1) && (j < 2 * extra);
         if (bus.dma_begin) begin
            if (pend_m) ovr_m = 1'b1;
            else        pend_m = 1'b1;
         end
         step();
         exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ovr_m};
         total++;
         if (obs() !== exp || bus.grant_cycles !== 16'(j + 1)) begin
            bad++;
            $display("FAIL %s grant[%0d]: %b cnt=%0d, want %b cnt=%0d", tag, j, obs(), bus.grant_cycles, exp, j + 1);
         end
      end
      // BR release
      bus.dma_begin = 1'b0; bus.BR = 1'b0; bus.cpu_mem_busy = 1'($urandom_range(0, 1));
      bus.dma_end = (mode == 0);
      fin = (mode != 2);
      step();
      exp = {1'b0, 1'b0, 1'b0, fin, !fin, ovr_m};
      total++;
      if (obs() !== exp || bus.grant_cycles !== 16'(L)) begin
         bad++; $display("FAIL %s release: %b cnt=%0d, want %b cnt=%0d", tag, obs(), bus.grant_cycles, exp, L);
      end
      if (mode == 2) begin
         bus.dma_end = 1'b0;
         for (int i = 0; i < e; i++) begin
            bus.cpu_mem_busy = 1'($urandom_range(0, 1));
            step();
            exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ovr_m};
            total++;
            if (obs() !== exp) begin
               bad++; $display("FAIL %s wait_end[%0d]: %b want %b", tag, i, obs(), exp);
            end
         end
         bus.dma_end = 1'b1;
         step();
         exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ovr_m};
         total++;
         if (obs() !== exp || bus.grant_cycles !== 16'(L)) begin
            bad++; $display("FAIL %s late_done: %b cnt=%0d, want %b cnt=%0d", tag, obs(), bus.grant_cycles, exp, L);
         end
      end
      idle_inputs();
      // without a queued request the arbiter rests in IDLE and done_irq is gone
      if (!pend_m) begin
         step();
         exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ovr_m};
         total++;
         if (obs() !== exp) begin
            bad++; $display("FAIL %s idle_after: %b want %b", tag, obs(), exp);
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      total++;
      if (obs() !== 6'b0 || bus.cmd_addr !== '0 || bus.cmd_length !== '0 || bus.grant_cycles !== '0) begin
         bad++;
         $display("FAIL reset: %b addr=%h len=%0d cnt=%0d, want all zero",
                  obs(), bus.cmd_addr, bus.cmd_length, bus.grant_cycles);
      end
      reset = 1'b0;
      pend_m = 1'b0; ovr_m = 1'b0;
   endtask

   task automatic test_basic();
      step();
      step();
      do_transfer(1'b0, 1, 0, 12, 0, 0, 0, "basic");
   endtask

   task automatic test_drain();
      do_transfer(1'b0, 0, 3, 4, 0, 0, 0, "drain");
   endtask

   task automatic test_late_end();
      do_transfer(1'b0, 0, 0, 3, 2, 5, 0, "late_end");
   endtask

   task automatic test_random();
      int w, d, L, mode, e;
      for (int n = 0; n < 20; n++) begin
         w    = $urandom_range(0, 3);
         d    = $urandom_range(0, 4);
         L    = $urandom_range(1, 8);
         mode = $urandom_range(0, 2);
         e    = $urandom_range(0, 5);
         if (mode == 1 && L < 2) mode = 0;
         do_transfer(1'b0, w, d, L, mode, e, 0, "random");
      end
   endtask

   task automatic test_back_to_back();
      do_transfer(1'b0, 0, 0, 6, 0, 0, 2, "b2b_first");
      do_transfer(1'b1, 1, 1, 3, 2, 2, 0, "b2b_second");
      step();
      total++;
      if (bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL b2b_sticky: overrun=%b busy=%b, want overrun=1 busy=0", bus.overrun, bus.busy);
      end
   endtask

   task automatic test_reset_mid_grant();
      idle_inputs();
      bus.dma_begin = 1'b1;
      step();
      bus.dma_begin = 1'b0;
      step();
      bus.BR = 1'b1;
      step();
      step();
      step();
      total++;
      if (bus.BG !== 1'b1) begin
         bad++; $display("FAIL rst_mid_pre: BG=%b want 1", bus.BG);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      pend_m = 1'b0; ovr_m = 1'b0;
      total++;
      if (obs() !== 6'b0 || bus.grant_cycles !== '0) begin
         bad++; $display("FAIL rst_mid: %b cnt=%0d, want all zero", obs(), bus.grant_cycles);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (obs() !== 6'b0) begin
            bad++; $display("FAIL rst_mid_br[%0d]: %b want 000000", i, obs());
         end
      end
      idle_inputs();
   endtask

   task automatic test_spurious();
      idle_inputs();
      bus.BR = 1'b1; bus.dma_end = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         total++;
         if (bus.BG !== 1'b0 || bus.cmd !== 1'b0 || bus.done_irq !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL spurious[%0d]: BG=%b cmd=%b done=%b busy=%b, want all 0",
                     i, bus.BG, bus.cmd, bus.done_irq, bus.busy);
         end
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_basic();
      test_drain();
      test_late_end();
      test_random();
      test_back_to_back();
      test_reset_mid_grant();
      test_spurious();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
